// File: rtl/lcd_display_table.sv
// Register table that answers lcd_module display queries, fed by touch input and a system write port.
// Optional build macro LCD_TBL_CURSOR_MARK_EN: the entry under the cursor shows '*' as its 5th name char.
module lcd_display_table #(
    parameter int                NUM_ENTRIES = 8,
    parameter int                BASE_NUMBER = 1,
    parameter int                DATA_W      = 32,
    parameter logic [DATA_W-1:0] RESET_VALUE = '0,
    localparam int               AW          = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [5:0]        display_number,
    output logic              display_valid,
    output logic [39:0]       display_name,
    output logic [DATA_W-1:0] display_value,
    input  logic              input_valid,
    input  logic [DATA_W-1:0] input_value,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_value,
    output logic [AW-1:0]     cursor
);

    localparam logic [6:0]    BASE_LO = 7'(BASE_NUMBER);
    localparam logic [6:0]    BASE_HI = 7'(BASE_NUMBER + NUM_ENTRIES);
    localparam logic [AW-1:0] LAST    = AW'(NUM_ENTRIES - 1);

    logic [DATA_W-1:0] entries [NUM_ENTRIES];
    logic [AW-1:0]     cursor_q;

    logic [6:0]        num_p0;
    logic [6:0]        idx_p0;
    logic [AW-1:0]     rd_idx_p0;
    logic              hit_p0;
    logic              mark_p0;

    logic              vld_p1;
    logic [39:0]       name_p1;
    logic [DATA_W-1:0] value_p1;

    // Two ASCII decimal digits of the entry index; the units digit becomes '*' when marked.
    function automatic logic [39:0] make_name(input logic [6:0] i, input logic mark);
        logic [6:0] tens;
        logic [6:0] units;
        tens  = i / 7'd10;
        units = i % 7'd10;
        return {"VAL", 8'h30 + {1'b0, tens}, mark ? 8'h2a : 8'h30 + {1'b0, units}};
    endfunction

    // Stage p0: decode the queried slot against the table window
    always_comb begin
        num_p0    = {1'b0, display_number};
        hit_p0    = (num_p0 >= BASE_LO) && (num_p0 < BASE_HI);
        idx_p0    = num_p0 - BASE_LO;
        rd_idx_p0 = idx_p0[AW-1:0];
`ifdef LCD_TBL_CURSOR_MARK_EN
        mark_p0   = (rd_idx_p0 == cursor_q);
`else
        mark_p0   = 1'b0;
`endif
    end

    // System write takes priority over a touch write to the same entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int j = 0; j < NUM_ENTRIES; j++) entries[j] <= RESET_VALUE;
            cursor_q <= '0;
        end else begin
            for (int j = 0; j < NUM_ENTRIES; j++) begin
                if (wr_en && (wr_addr == AW'(j)))
                    entries[j] <= wr_value;
                else if (input_valid && (cursor_q == AW'(j)))
                    entries[j] <= input_value;
            end
            if (input_valid)
                cursor_q <= (cursor_q == LAST) ? '0 : cursor_q + AW'(1);
        end
    end

    // Stage p1: registered query response (reads pre-write table contents)
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_p1   <= 1'b0;
            name_p1  <= '0;
            value_p1 <= '0;
        end else begin
            vld_p1   <= hit_p0;
            name_p1  <= hit_p0 ? make_name(idx_p0, mark_p0) : '0;
            value_p1 <= hit_p0 ? entries[rd_idx_p0] : '0;
        end
    end

    assign display_valid = vld_p1;
    assign display_name  = name_p1;
    assign display_value = value_p1;
    assign cursor        = cursor_q;

endmodule

// File: tb/tb_lcd_display_table.sv
// Directed self-checking bench for lcd_display_table (default parameters).
module tb_lcd_display_table;

    logic        clk;
    logic        resetn;
    logic [5:0]  display_number;
    logic        display_valid;
    logic [39:0] display_name;
    logic [31:0] display_value;
    logic        input_valid;
    logic [31:0] input_value;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_value;
    logic [2:0]  cursor;

    int n_tests = 0;
    int n_fail  = 0;

    lcd_display_table dut (
        .clk            (clk),
        .resetn         (resetn),
        .display_number (display_number),
        .display_valid  (display_valid),
        .display_name   (display_name),
        .display_value  (display_value),
        .input_valid    (input_valid),
        .input_value    (input_value),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_value       (wr_value),
        .cursor         (cursor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected name for entry i (< 10); marked only when the mark feature is built in.
    function automatic logic [39:0] nm(input int i, input bit at_cursor);
        logic [7:0] last;
        last = 8'h30 + 8'(i);
`ifdef LCD_TBL_CURSOR_MARK_EN
        if (at_cursor) last = 8'h2a;
`endif
        return {"VAL0", last};
    endfunction

    int exp_tab [8] = '{9, 2, 3, 4, 5, 6, 7, 8};

    initial begin
        resetn = 1'b0; display_number = '0; input_valid = 1'b0; input_value = '0;
        wr_en = 1'b0; wr_addr = '0; wr_value = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(display_valid), 64'd0);
        chk("rst_name",  64'(display_name),  64'd0);
        chk("rst_value", 64'(display_value), 64'd0);
        chk("rst_cursor", 64'(cursor), 64'd0);
        #3 resetn = 1'b1;

        // Basic queries
        display_number = 6'd1; tick();
        chk("q1_valid", 64'(display_valid), 64'd1);
        chk("q1_name",  64'(display_name),  64'(nm(0, 1)));
        chk("q1_value", 64'(display_value), 64'd0);
        display_number = 6'd0; tick();
        chk("q0_valid", 64'(display_valid), 64'd0);
        chk("q0_name",  64'(display_name),  64'd0);
        chk("q0_value", 64'(display_value), 64'd0);
        display_number = 6'd9; tick();
        chk("q9_valid", 64'(display_valid), 64'd0);
        chk("q9_name",  64'(display_name),  64'd0);
        chk("q9_value", 64'(display_value), 64'd0);
        display_number = 6'd8; tick();
        chk("q8_valid", 64'(display_valid), 64'd1);
        chk("q8_name",  64'(display_name),  64'("VAL07"));

        // System write then query
        wr_en = 1'b1; wr_addr = 3'd3; wr_value = 32'd20241106; tick();
        wr_en = 1'b0; display_number = 6'd4; tick();
        chk("sys_wr_value", 64'(display_value), 64'd20241106);
        chk("sys_wr_name",  64'(display_name),  64'("VAL03"));
        chk("sys_wr_cursor", 64'(cursor), 64'd0);

        // Read during write returns the old value, next query the new one
        display_number = 6'd3; wr_en = 1'b1; wr_addr = 3'd2; wr_value = 32'd77; tick();
        chk("rdw_old", 64'(display_value), 64'd0);
        wr_en = 1'b0; tick();
        chk("rdw_new", 64'(display_value), 64'd77);

        // input_valid held for 9 cycles: 9 writes, cursor wraps to 1
        input_valid = 1'b1;
        for (int v = 1; v <= 9; v++) begin
            input_value = 32'(v); tick();
        end
        input_valid = 1'b0;
        chk("touch_cursor_wrap", 64'(cursor), 64'd1);
        for (int i = 0; i < 8; i++) begin
            display_number = 6'(i + 1); tick();
            chk($sformatf("touch_entry%0d", i), 64'(display_value), 64'(exp_tab[i]));
        end
        display_number = 6'd2; tick();
        chk("touch_name1", 64'(display_name), 64'(nm(1, 1)));

        // Advance cursor to 2, then collide with a system write on entry 2
        input_valid = 1'b1; input_value = 32'd100; tick();
        chk("touch_cursor2", 64'(cursor), 64'd2);
        input_value = 32'd5; wr_en = 1'b1; wr_addr = 3'd2; wr_value = 32'd7; tick();
        input_valid = 1'b0; wr_en = 1'b0;
        chk("same_cursor", 64'(cursor), 64'd3);
        display_number = 6'd3; tick();
        chk("same_entry2", 64'(display_value), 64'd7);
        display_number = 6'd2; tick();
        chk("same_entry1", 64'(display_value), 64'd100);

        // Different entries written in one cycle
        input_valid = 1'b1; input_value = 32'd11; wr_en = 1'b1; wr_addr = 3'd5; wr_value = 32'd55; tick();
        input_valid = 1'b0; wr_en = 1'b0;
        chk("diff_cursor", 64'(cursor), 64'd4);
        display_number = 6'd4; tick();
        chk("diff_touch", 64'(display_value), 64'd11);
        display_number = 6'd6; tick();
        chk("diff_sys", 64'(display_value), 64'd55);
        display_number = 6'd5; tick();
        chk("cursor_name", 64'(display_name), 64'(nm(4, 1)));
        chk("cursor_value", 64'(display_value), 64'd5);

        // Reset mid-operation with writes pending
        input_valid = 1'b1; input_value = 32'd99; wr_en = 1'b1; wr_addr = 3'd6; wr_value = 32'd66;
        display_number = 6'd2;
        #2 resetn = 1'b0;
        #1;
        chk("midrst_valid", 64'(display_valid), 64'd0);
        chk("midrst_name",  64'(display_name),  64'd0);
        chk("midrst_value", 64'(display_value), 64'd0);
        chk("midrst_cursor", 64'(cursor), 64'd0);
        tick();
        input_valid = 1'b0; wr_en = 1'b0;
        #2 resetn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            display_number = 6'(i + 1); tick();
            chk($sformatf("cleared_entry%0d", i), 64'(display_value), 64'd0);
        end
        display_number = 6'd1; tick();
        chk("post_rst_name", 64'(display_name), 64'(nm(0, 1)));
        chk("post_rst_cursor", 64'(cursor), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
